burst_producer: RTL and testbench
=================================

BURST_PRODUCER -- requirements
Module: burst_producer

Interface
REQ-001 Parameter P_DATA_WIDTH, default 8: width of each produced data word.
REQ-002 Parameter P_MAX_BURST, default 1024: maximum words per burst.
REQ-003 Parameter P_IDLE_WIDTH, default 4: width of the inter-write idle count.
REQ-004 PROD_CLK  input  1: producer clock; all state changes on its rising edge.
REQ-005 RST  input  1: reset, synchronous, active-high, sampled on the PROD_CLK rising edge.
REQ-006 START  input  1: single-cycle burst request.
REQ-007 BURST_LEN  input  $clog2(P_MAX_BURST+1): number of words requested.
REQ-008 IDLE_CYCLES  input  P_IDLE_WIDTH: idle cycles inserted after each accepted write.
REQ-009 FULL  input  1: FIFO full flag from the async_fifo write side.
REQ-010 W_EN  output  1: write enable to async_fifo.
REQ-011 DATA_OUT  output  P_DATA_WIDTH: write data to async_fifo DATA_IN.
REQ-012 BUSY  output  1: burst in progress.
REQ-013 DONE  output  1: one-cycle pulse on burst completion.
REQ-014 WR_COUNT  output  $clog2(P_MAX_BURST+1): words accepted in the current or last burst.

Function
REQ-015 The FSM SHALL use four states: IDLE, WRITE, GAP, FINISH.
REQ-016 In IDLE with START=1, the block SHALL latch BURST_LEN, clamped to P_MAX_BURST, and IDLE_CYCLES, clear WR_COUNT, and load DATA_OUT with 1.
REQ-017 On that same START edge, the next state SHALL be WRITE, or FINISH if the latched length is 0.
REQ-018 START SHALL be ignored in every state other than IDLE.
REQ-019 W_EN SHALL be combinational: (state==WRITE) && !FULL.
REQ-020 A write is accepted on each rising edge where W_EN=1.
REQ-021 While FULL=1 in WRITE, the block SHALL hold state, DATA_OUT, and WR_COUNT unchanged (stall).
REQ-022 On each accepted write, WR_COUNT SHALL increment by 1 and DATA_OUT SHALL increment by 1, modulo 2^P_DATA_WIDTH, so word i carries (i+1) mod 2^P_DATA_WIDTH.
REQ-023 After an accepted write that is the last word (WR_COUNT+1 == latched length), the next state SHALL be FINISH.
REQ-024 After any other accepted write, the next state SHALL be GAP if latched IDLE_CYCLES>0, else WRITE.
REQ-025 With IDLE_CYCLES=0, the block SHALL be able to accept one write per cycle.
REQ-026 GAP SHALL last exactly the latched IDLE_CYCLES cycles, counted by an internal down-counter, then return to WRITE.
REQ-027 W_EN SHALL be 0 throughout GAP regardless of FULL.
REQ-028 FINISH SHALL last one cycle, with DONE=1, then go to IDLE.
REQ-029 DONE SHALL be 0 in every state other than FINISH.
REQ-030 BUSY SHALL be 1 in WRITE, GAP, and FINISH, and 0 in IDLE.
REQ-031 WR_COUNT SHALL hold its final value in IDLE until the next accepted START.
REQ-032 The block SHALL never issue more than the latched length of writes per burst.
REQ-033 FULL toggling on the final word SHALL delay FINISH until that word is accepted.
REQ-034 Changes to BURST_LEN or IDLE_CYCLES during a burst SHALL have no effect.

Reset
REQ-035 RST=1 at a rising edge SHALL force state IDLE and clear DATA_OUT, WR_COUNT, the gap counter, and the latched length and idle values to 0.
REQ-036 Outputs during and after reset SHALL be BUSY=0, DONE=0, W_EN=0.
REQ-037 RST SHALL take priority over START in the same cycle.
REQ-038 Reset mid-burst SHALL abort the burst with no DONE pulse and no further W_EN.
REQ-039 After RST deasserts, the block SHALL accept START on the next edge.

Verification
REQ-040 Basic burst: BURST_LEN=4, IDLE_CYCLES=0, FULL=0, START pulse -> W_EN high 4 consecutive cycles, DATA_OUT 1,2,3,4, DONE pulse 1 cycle after the 4th write, WR_COUNT=4.
REQ-041 Idle spacing: BURST_LEN=3, IDLE_CYCLES=2 -> writes 3 cycles apart (W_EN pattern 1,0,0,1,0,0,1), DONE then follows.
REQ-042 Backpressure: BURST_LEN=5, FULL held high for 6 cycles after the 2nd write -> W_EN=0 and DATA_OUT=3 held during stall, then words 3..5 written, total WR_COUNT=5.
REQ-043 Edge lengths: BURST_LEN=0 -> no W_EN, DONE 1 cycle after START; BURST_LEN=2047 -> clamped to 1024 writes, DATA_OUT wraps 255->0 at word 256.
REQ-044 Reset mid-burst: RST after 10 of 20 writes -> W_EN=0, BUSY=0, WR_COUNT=0, no DONE; a new START with BURST_LEN=2 then yields DATA_OUT 1,2.
REQ-045 START while BUSY: second START during a burst of 8 is ignored -> exactly 8 writes and a single DONE.

Source files
------------

// File: rtl/burst_producer.sv
// -----------------------------------------------------------------------------
// burst_producer
//
// Generates a burst of incrementing data words into the write side of an
// async_fifo. A START pulse in IDLE latches the requested length (clamped to
// P_MAX_BURST) and an inter-write idle count. Each accepted write (W_EN high
// at a rising edge) advances DATA_OUT and WR_COUNT. A programmable number of
// GAP cycles can follow every non-final write. FULL stalls the producer in
// WRITE without losing or repeating a word. A one-cycle DONE pulse in FINISH
// marks the end of the burst.
//
// Ports
//   PROD_CLK     in   producer clock, all state changes on its rising edge
//   RST          in   synchronous active-high reset
//   START        in   single-cycle burst request, honoured only in IDLE
//   BURST_LEN    in   requested word count (clamped to P_MAX_BURST)
//   IDLE_CYCLES  in   idle cycles inserted after each non-final write
//   FULL         in   FIFO full flag; blocks writes while high
//   W_EN         out  FIFO write enable, (state == WRITE) && !FULL
//   DATA_OUT     out  FIFO write data; word i carries (i+1) mod 2^P_DATA_WIDTH
//   BUSY         out  high in WRITE, GAP and FINISH
//   DONE         out  one-cycle completion pulse
//   WR_COUNT     out  words accepted in the current or last burst
// -----------------------------------------------------------------------------
module burst_producer #(
  parameter int  P_DATA_WIDTH = 8,
  parameter int  P_MAX_BURST  = 1024,
  parameter int  P_IDLE_WIDTH = 4,
  localparam int LEN_W        = $clog2(P_MAX_BURST + 1)
) (
  input  logic                    PROD_CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [LEN_W-1:0]        BURST_LEN,
  input  logic [P_IDLE_WIDTH-1:0] IDLE_CYCLES,
  input  logic                    FULL,
  output logic                    W_EN,
  output logic [P_DATA_WIDTH-1:0] DATA_OUT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [LEN_W-1:0]        WR_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_FINISH
  } state_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_clamped;
  logic [LEN_W-1:0]        wr_count_q;
  logic [P_DATA_WIDTH-1:0] data_q;
  logic [P_IDLE_WIDTH-1:0] idle_q;
  logic [P_IDLE_WIDTH-1:0] gap_cnt;
  logic                    accept;
  logic                    last_word;

  assign len_clamped = (BURST_LEN > LEN_W'(P_MAX_BURST)) ? LEN_W'(P_MAX_BURST)
                                                         : BURST_LEN;

  // A write is accepted exactly when the FIFO sees W_EN at the edge.
  assign accept    = (state == ST_WRITE) && !FULL;
  assign last_word = (wr_count_q + LEN_W'(1)) == len_q;

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = (len_clamped == '0) ? ST_FINISH : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!FULL) begin
          if (last_word) begin
            state_nxt = ST_FINISH;
          end else if (idle_q != '0) begin
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_WRITE;
          end
        end
      end
      ST_GAP: begin
        // gap_cnt is loaded with idle_q on entry, so the last GAP cycle is
        // the one where it reads 1.
        if (gap_cnt <= P_IDLE_WIDTH'(1)) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge PROD_CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      idle_q     <= '0;
      wr_count_q <= '0;
      data_q     <= '0;
      gap_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (START) begin
            len_q      <= len_clamped;
            idle_q     <= IDLE_CYCLES;
            wr_count_q <= '0;
            data_q     <= P_DATA_WIDTH'(1);
          end
        end
        ST_WRITE: begin
          if (accept) begin
            wr_count_q <= wr_count_q + LEN_W'(1);
            data_q     <= data_q + P_DATA_WIDTH'(1);
            gap_cnt    <= idle_q;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - P_IDLE_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign W_EN     = accept;
  assign BUSY     = (state != ST_IDLE);
  assign DONE     = (state == ST_FINISH);
  assign DATA_OUT = data_q;
  assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_burst_producer.sv
// -----------------------------------------------------------------------------
// tb_burst_producer
//
// Scoreboard bench for burst_producer. Each burst request pushes the words it
// should produce (data value and WR_COUNT at presentation) and the expected
// final count onto queues; a monitor pops and compares whenever W_EN or DONE
// is seen. Directed W_EN/DONE patterns cover spacing, stalls and edge lengths.
// -----------------------------------------------------------------------------
module tb_burst_producer;

  localparam int DW    = 8;
  localparam int MAXB  = 1024;
  localparam int IW    = 4;
  localparam int LEN_W = $clog2(MAXB + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic [IW-1:0]    idle_cycles;
  logic             full;
  logic             w_en;
  logic [DW-1:0]    data_out;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] wr_count;

  burst_producer #(
    .P_DATA_WIDTH(DW),
    .P_MAX_BURST (MAXB),
    .P_IDLE_WIDTH(IW)
  ) dut (
    .PROD_CLK   (clk),
    .RST        (rst),
    .START      (start),
    .BURST_LEN  (burst_len),
    .IDLE_CYCLES(idle_cycles),
    .FULL       (full),
    .W_EN       (w_en),
    .DATA_OUT   (data_out),
    .BUSY       (busy),
    .DONE       (done),
    .WR_COUNT   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes scoreboard entries as the DUT presents writes / DONE.
  exp_t mon_e;
  int   mon_n;
  always @(negedge clk) begin
    if (w_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_w_en", w_en, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", data_out, mon_e.data);
        check("wr_count_at_write", wr_count, mon_e.cnt);
      end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        mon_n = done_q.pop_front();
        check("wr_count_at_done", wr_count, mon_n);
        check("words_missing_at_done", exp_q.size(), 0);
      end
    end
  end

  // Issue a START pulse and record what the burst should produce. Returns
  // #1 after the edge that samples START.
  task automatic start_burst(input int len, input int idle);
    int n;
    n = (len > MAXB) ? MAXB : len;
    @(posedge clk);
    #1;
    burst_len   = LEN_W'(len);
    idle_cycles = IW'(idle);
    start       = 1'b1;
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back('{data: i % 256, cnt: i - 1});
    end
    done_q.push_back(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One char per cycle: '1' W_EN high, '0' W_EN and DONE low, 'D' DONE pulse.
  task automatic check_pattern(input string name, input string pat);
    for (int k = 0; k < pat.len(); k++) begin
      @(negedge clk);
      if (pat.getc(k) == "D") begin
        check({name, "_done"}, done, 1);
        check({name, "_w_en"}, w_en, 0);
      end else begin
        check({name, "_w_en"}, w_en, (pat.getc(k) == "1") ? 1 : 0);
        check({name, "_no_done"}, done, 0);
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    burst_len   = '0;
    idle_cycles = '0;
    full        = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_en", w_en, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_data_out", data_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic burst: 4 back-to-back writes, DONE the cycle after the 4th
    start_burst(4, 0);
    check_pattern("basic", "1111D");
    @(negedge clk);
    check("basic_final_count", wr_count, 4);
    check("basic_idle_busy", busy, 0);

    // Idle spacing: writes three cycles apart
    start_burst(3, 2);
    check_pattern("gap", "1001001D");

    // Backpressure: FULL high for 6 cycles after the 2nd write
    start_burst(5, 0);
    check_pattern("bp_pre", "11");
    @(posedge clk);
    #1;
    full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_stall_w_en", w_en, 0);
      check("bp_stall_data", data_out, 3);
      check("bp_stall_count", wr_count, 2);
      check("bp_stall_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    full = 1'b0;
    check_pattern("bp_post", "111D");

    // FULL on the final word delays FINISH
    start_burst(2, 0);
    check_pattern("last_full_a", "1");
    @(posedge clk);
    #1;
    full = 1'b1;
    check_pattern("last_full_stall", "00");
    @(posedge clk);
    #1;
    full = 1'b0;
    check_pattern("last_full_b", "1D");

    // Zero length: DONE one cycle after START, no writes
    start_burst(0, 0);
    check_pattern("len0", "D");

    // Over-long request clamps to 1024 writes; data wraps 255 -> 0
    start_burst(2047, 0);
    wait_done("clamp", 1100);
    @(negedge clk);
    check("clamp_final_count", wr_count, 1024);
    check("clamp_busy", busy, 0);

    // Reset mid-burst (with START held, which must not win over RST)
    start_burst(20, 0);
    repeat (10) @(negedge clk);
    #1;
    rst         = 1'b1;
    start       = 1'b1;
    burst_len   = LEN_W'(7);
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    check("rst_mid_w_en", w_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", wr_count, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_data", data_out, 0);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_burst(2, 0);
    check_pattern("post_rst", "11D");

    // Second START during a burst of 8 is ignored, new inputs have no effect
    start_burst(8, 0);
    check_pattern("busy_start_a", "111");
    #1;
    start       = 1'b1;
    burst_len   = LEN_W'(3);
    idle_cycles = IW'(5);
    check_pattern("busy_start_b", "1");
    #1;
    start = 1'b0;
    check_pattern("busy_start_c", "1111D0");

    repeat (3) @(negedge clk);
    check("end_pending_writes", exp_q.size(), 0);
    check("end_pending_dones", done_q.size(), 0);
    check("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
